// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states, mux selects.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_R_WB      = 4'd7,
    ST_BRANCH    = 4'd8,
    ST_JUMP      = 4'd9,
    ST_ADDI_EX   = 4'd10,
    ST_ADDI_WB   = 4'd11,
    ST_ILLEGAL   = 4'd12
  } state_t;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  // Full set of datapath controls produced by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/mc_out_decode.sv
// Combinational decode of FSM state into datapath controls.
// Latency: zero cycles (pure combinational).
// Backpressure: mem_ready gates the fetch load strobes and store retirement only.
module mc_out_decode
  import mips_pkg::*;
(
  input  logic [3:0]        state,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl
);

  state_t st;
  ctrl_t  c;

  assign st   = state_t'(state);
  assign ctrl = c;

  // Moore decode per state; everything not named in a state stays 0.
  always_comb begin
    c = '0;
    unique case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_MEM_READ: begin
        c.i_or_d   = 1'b1;
        c.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_MEM_WRITE: begin
        // Strobe held for the whole wait; retirement only on the completing cycle.
        c.i_or_d     = 1'b1;
        c.mem_write  = 1'b1;
        c.instr_done = mem_ready;
      end
      ST_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALUOP_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
        c.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = PCSRC_JUMP;
        c.instr_done = 1'b1;
      end
      ST_ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      ST_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: begin
        c = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main multi-cycle MIPS control FSM with retired-instruction counter.
// Latency: lw 5, sw/R/addi 4, beq/j 3 cycles, plus one per memory wait cycle.
// Backpressure: stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready; illegal opcode halts until reset.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_op1,
  output logic             alu_op0,
  output logic [1:0]       pc_source,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic             is_store_q, is_store_d;  // lw vs sw, captured in DECODE
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec;

  mc_out_decode u_out_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (dec)
  );

  // Next-state, opcode capture, sticky illegal flag and retirement count.
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    illegal_d  = illegal_q;
    cnt_d      = cnt_q + CNT_W'(dec.instr_done);
    unique case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (opcode)
          OP_LW:    begin state_d = ST_MEM_ADDR; is_store_d = 1'b0; end
          OP_SW:    begin state_d = ST_MEM_ADDR; is_store_d = 1'b1; end
          OP_RTYPE: state_d = ST_EXECUTE;
          OP_BEQ:   state_d = ST_BRANCH;
          OP_J:     state_d = ST_JUMP;
          OP_ADDI:  state_d = ST_ADDI_EX;
          default:  begin state_d = ST_ILLEGAL; illegal_d = 1'b1; end
        endcase
      end
      ST_MEM_ADDR:  state_d = is_store_q ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_R_WB:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_ADDI_EX:   state_d = ST_ADDI_WB;
      ST_ADDI_WB:   state_d = ST_FETCH;
      ST_ILLEGAL:   state_d = ST_ILLEGAL;
      default:      state_d = ST_FETCH;
    endcase
  end

  // State, capture and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      is_store_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  // Write enables (and retirement) are suppressed while reset is asserted.
  assign pc_write      = dec.pc_write      & rst_n;
  assign pc_write_cond = dec.pc_write_cond & rst_n;
  assign ir_write      = dec.ir_write      & rst_n;
  assign reg_write     = dec.reg_write     & rst_n;
  assign mem_write     = dec.mem_write     & rst_n;
  assign instr_done    = dec.instr_done    & rst_n;

  assign i_or_d      = dec.i_or_d;
  assign mem_read    = dec.mem_read;
  assign mem_to_reg  = dec.mem_to_reg;
  assign reg_dst     = dec.reg_dst;
  assign alu_src_a   = dec.alu_src_a;
  assign alu_src_b   = dec.alu_src_b;
  assign alu_op1     = dec.alu_op[1];
  assign alu_op0     = dec.alu_op[0];
  assign pc_source   = dec.pc_source;
  assign illegal     = illegal_q | dec.illegal;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios then random instruction stream.
// Latency: checks every cycle on the falling edge against a per-instruction cycle plan.
// Backpressure: mem_ready wait cycles chosen per instruction, random in don't-care states.
module tb_multicycle_ctrl;
  import mips_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [5:0]    opcode;
  logic          mem_ready;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, alu_op1, alu_op0;
  logic [1:0]    alu_src_b, pc_source;
  logic          instr_done, illegal;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int cnt_exp = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op1(alu_op1),
    .alu_op0(alu_op0), .pc_source(pc_source), .instr_done(instr_done),
    .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Output vector in a fixed field order, compared as a whole.
  function automatic logic [17:0] dut_vec();
    return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
            mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op1,
            alu_op0, pc_source, instr_done, illegal};
  endfunction

  // Control table written straight from the per-state output list.
  function automatic logic [17:0] exp_vec(input logic [3:0] s, input logic r);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il;
    logic [1:0] sb, op, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn, il} = '0;
    sb = 2'b00; op = 2'b00; ps = 2'b00;
    case (s)
      ST_FETCH:     begin mr = 1; sb = 2'b01; irw = r; pw = r; end
      ST_DECODE:    sb = 2'b11;
      ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
      ST_MEM_READ:  begin iod = 1; mr = 1; end
      ST_MEM_WB:    begin rw = 1; m2r = 1; dn = 1; end
      ST_MEM_WRITE: begin iod = 1; mw = 1; dn = r; end
      ST_EXECUTE:   begin sa = 1; op = 2'b10; end
      ST_R_WB:      begin rd = 1; rw = 1; dn = 1; end
      ST_BRANCH:    begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; dn = 1; end
      ST_JUMP:      begin pw = 1; ps = 2'b10; dn = 1; end
      ST_ADDI_EX:   begin sa = 1; sb = 2'b10; end
      ST_ADDI_WB:   begin rw = 1; dn = 1; end
      ST_ILLEGAL:   il = 1;
      default:      ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, dn, il};
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Run one instruction: fw FETCH wait cycles, mw memory wait cycles.
  // abort_at >= 0 stops after that many cycles (instruction left mid-flight).
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int abort_at);
    logic [3:0] sq[$];
    logic       rq[$];
    logic [17:0] e;
    for (int i = 0; i < fw; i++) begin sq.push_back(ST_FETCH); rq.push_back(1'b0); end
    sq.push_back(ST_FETCH);  rq.push_back(1'b1);
    sq.push_back(ST_DECODE); rq.push_back(rnd_bit());
    case (op)
      OP_LW, OP_SW: begin
        sq.push_back(ST_MEM_ADDR); rq.push_back(rnd_bit());
        for (int i = 0; i < mw; i++) begin
          sq.push_back(op == OP_LW ? ST_MEM_READ : ST_MEM_WRITE); rq.push_back(1'b0);
        end
        sq.push_back(op == OP_LW ? ST_MEM_READ : ST_MEM_WRITE); rq.push_back(1'b1);
        if (op == OP_LW) begin sq.push_back(ST_MEM_WB); rq.push_back(rnd_bit()); end
      end
      OP_RTYPE: begin
        sq.push_back(ST_EXECUTE); rq.push_back(rnd_bit());
        sq.push_back(ST_R_WB);    rq.push_back(rnd_bit());
      end
      OP_BEQ:  begin sq.push_back(ST_BRANCH); rq.push_back(rnd_bit()); end
      OP_J:    begin sq.push_back(ST_JUMP);   rq.push_back(rnd_bit()); end
      OP_ADDI: begin
        sq.push_back(ST_ADDI_EX); rq.push_back(rnd_bit());
        sq.push_back(ST_ADDI_WB); rq.push_back(rnd_bit());
      end
      default: for (int i = 0; i < 5; i++) begin sq.push_back(ST_ILLEGAL); rq.push_back(rnd_bit()); end
    endcase
    for (int k = 0; k < sq.size(); k++) begin
      if (abort_at >= 0 && k == abort_at) return;
      mem_ready = rq[k];
      // Opcode is only meaningful through DECODE; scramble it afterwards.
      opcode = (k <= fw + 1) ? op : 6'($urandom);
      @(negedge clk);
      e = exp_vec(sq[k], rq[k]);
      check("state", 32'(state), 32'(sq[k]));
      check("ctrl", 32'(dut_vec()), 32'(e));
      check("count", 32'(instr_count), 32'(cnt_exp % (1 << CW)));
      @(posedge clk); #1;
      if (e[1]) cnt_exp++;
    end
  endtask

  // One reset edge with mem_ready high: write enables must be forced low meanwhile.
  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    check("rst_wen", 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_exp = 0;
    @(negedge clk);
    check("rst_state", 32'(state), 32'(ST_FETCH));
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    // Leave the bench aligned just after a rising edge with the DUT in FETCH.
    mem_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops[0] = OP_RTYPE; legal_ops[1] = OP_LW;  legal_ops[2] = OP_SW;
    legal_ops[3] = OP_BEQ;   legal_ops[4] = OP_J;   legal_ops[5] = OP_ADDI;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();

    run_instr(OP_LW, 0, 0, -1);                      // 5 cycles, count 1
    check("lw_count", 32'(instr_count), 32'd1);
    run_instr(OP_SW, 0, 2, -1);                      // 6 cycles, mem_write held 3
    run_instr(OP_RTYPE, 0, 0, -1);
    run_instr(OP_BEQ, 0, 0, -1);
    run_instr(OP_J, 0, 0, -1);
    check("rbj_count", 32'(instr_count), 32'd5);
    run_instr(OP_ADDI, 0, 0, -1);
    run_instr(OP_RTYPE, 4, 0, -1);                   // FETCH stall 4 cycles

    run_instr(6'b111111, 0, 0, -1);                  // illegal, sticky, frozen
    check("ill_sticky", 32'(illegal), 32'd1);
    do_reset();

    run_instr(OP_LW, 0, 3, 4);                       // abandon in MEM_READ
    check("abort_state", 32'(state), 32'(ST_MEM_READ));
    do_reset();

    // Random stream long enough to wrap the 4-bit counter several times.
    for (int n = 0; n < 40; n++) begin
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end
    check("final_count", 32'(instr_count), 32'(cnt_exp % (1 << CW)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
